exe_stage: RTL
==============

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have parameter MUL_STEPS, default 32, meaning iterations of the shift-add multiplier (1..32).
REQ-002 SHALL have parameter NOP_TYPE, default 4'd0, meaning the ins_type code driven for a bubble.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports id_wreg, id_m2reg, id_wmem  in  1 each  control bits from decode.
REQ-006 SHALL have ports id_aluc  in  4  ALU op; id_aluimm  in  1  use immediate as B; id_shift  in  1  use shamt as A.
REQ-007 SHALL have ports id_inA, id_inB, id_imm  in  32 each  operands and sign/zero-extended immediate.
REQ-008 SHALL have ports id_destR  in  5; ID_ins_type, ID_ins_number  in  4 each  debug tags.
REQ-009 SHALL have ports ex_wreg, ex_m2reg, ex_wmem  out  1 each; ex_aluR, ex_inB  out  32 each; ex_destR  out  5.
REQ-010 SHALL have ports EXE_ins_type, EXE_ins_number  out  4 each; ex_stall  out  1  freeze request to fetch/decode.

Function
REQ-011 SHALL latch all id_* inputs into the ID/EXE register on each rising clk when ex_stall=0, and hold them when ex_stall=1.
REQ-012 SHALL compute B = id_aluimm ? imm : inB and A = id_shift ? {27'b0, imm[10:6]} : inA from registered values.
REQ-013 SHALL implement aluc: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI ({B[15:0],16'b0}), 12 MUL; shifts use A[4:0] as amount, B as value; ADD/SUB wrap modulo 2^32, no overflow trap.
REQ-014 SHALL drive all non-MUL results combinationally from the ID/EXE register: zero added latency beyond the register.
REQ-015 SHALL drive ex_inB = registered inB (not the muxed B) and ex_destR = registered destR.
REQ-016 SHALL run the multiplier FSM: IDLE -> BUSY when registered aluc=12 in IDLE; BUSY counts 0..MUL_STEPS-1; BUSY -> DONE after the last step; DONE -> IDLE after one cycle.
REQ-017 SHALL assert ex_stall in IDLE while registered aluc=12 and throughout BUSY; ex_stall=0 in DONE.
REQ-018 SHALL present ex_aluR = low 32 bits of unsigned product in DONE, with registered control bits and tags.
REQ-019 SHALL force ex_wreg=ex_m2reg=ex_wmem=0 and EXE_ins_type=NOP_TYPE while ex_stall=1, so the downstream register captures bubbles.
REQ-020 SHALL start a new MUL when back-to-back MULs are issued: the second is latched in DONE and enters BUSY next cycle.
REQ-021 SHALL treat undefined aluc (13..15) as result 0 with control bits passed through.

Reset
REQ-022 SHALL on rst_n=0 clear the ID/EXE register, product, counter to 0 and FSM to IDLE, regardless of clk.
REQ-023 SHALL abort an in-flight MUL on reset; after release outputs are all 0, ex_stall=0, EXE_ins_type=NOP_TYPE.

Configuration
REQ-024 SHALL compile the multiplier FSM only when EXE_MULDIV_EN is defined.
REQ-025 SHALL, without EXE_MULDIV_EN, treat aluc=12 as undefined (REQ-021) and tie ex_stall to 0.

Structure
REQ-026 SHALL place aluc codes, FSM state encoding and NOP_TYPE default in shared package exe_pkg.
REQ-027 SHALL implement the multiplier as sub-module mul_seq (start, busy, done, 64-bit product), instantiated only under EXE_MULDIV_EN.

Verification
REQ-028 SHALL check: inA=7, inB=5, aluc=1 -> ex_aluR=2 the cycle after latch, ex_stall=0.
REQ-029 SHALL check: inB=0x80000000, imm shamt=4, aluc=10, shift=1 -> ex_aluR=0xF8000000.
REQ-030 SHALL check: MUL inA=0xFFFF, inB=0x10001, MUL_STEPS=32 -> ex_stall high 33 cycles, ex_wreg=0 meanwhile, then ex_aluR=0xFFFFFFFF.
REQ-031 SHALL check: two back-to-back MULs (3*4, 5*6) -> results 12 then 30, each with one DONE cycle, no lost instruction.
REQ-032 SHALL check: rst_n low at BUSY step 10 -> ex_stall=0 immediately, outputs 0, next ADD 1+1 gives 2.
REQ-033 SHALL check: build without EXE_MULDIV_EN, aluc=12 -> ex_aluR=0, ex_stall never asserted.

Source files
------------

// File: rtl/exe_pkg.sv
// ---------------------------------------------------------------------------
// exe_pkg -- shared definitions for the execute stage.
//   * ALU operation codes carried on id_aluc
//   * multiplier FSM state encoding
//   * default ins_type tag used for pipeline bubbles
// ---------------------------------------------------------------------------
package exe_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;
    localparam logic [3:0] ALU_MUL  = 4'd12;

    localparam logic [3:0] NOP_TYPE_DEFAULT = 4'd0;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/exe_stage_mul_seq.sv
// ---------------------------------------------------------------------------
// mul_seq -- iterative shift-add unsigned multiplier.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : operands a/b are valid; sampled only while IDLE
//   a, b         : 32-bit unsigned operands
//   busy         : iterating (one partial product per cycle)
//   done         : product valid for exactly this cycle
//   product      : 64-bit accumulator (full product when STEPS=32)
//   state        : FSM state, exposed for debug/checkers
// IDLE -> BUSY on start; BUSY runs STEPS cycles; DONE lasts one cycle.
// ---------------------------------------------------------------------------
module mul_seq import exe_pkg::*; #(
    parameter int STEPS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product,
    output mul_state_t  state
);

    localparam logic [5:0] LAST = 6'(STEPS - 1);

    mul_state_t  state_q, state_d;
    logic [63:0] acc, mcand;
    logic [31:0] mplier;
    logic [5:0]  count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= MUL_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL_IDLE: if (start)         state_d = MUL_BUSY;
            MUL_BUSY: if (count == LAST) state_d = MUL_DONE;
            MUL_DONE:                    state_d = MUL_IDLE;
            default:                     state_d = MUL_IDLE;
        endcase
    end

    // Multiplicand shifts left and multiplier shifts right each step, so the
    // LSB of mplier always selects whether the current mcand is accumulated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (state_q == MUL_IDLE && start) begin
            acc    <= '0;
            mcand  <= {32'b0, a};
            mplier <= b;
            count  <= '0;
        end else if (state_q == MUL_BUSY) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 6'd1;
        end
    end

    assign busy    = (state_q == MUL_BUSY);
    assign done    = (state_q == MUL_DONE);
    assign product = acc;
    assign state   = state_q;

endmodule

// File: rtl/exe_stage.sv
// ---------------------------------------------------------------------------
// exe_stage -- pipeline execute stage: ID/EXE register + single-cycle ALU,
// with an optional sequential multiplier (aluc=12).
// Optional feature macro: EXE_MULDIV_EN (enables mul_seq and ex_stall).
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   id_wreg/id_m2reg/id_wmem    : control bits from decode
//   id_aluc, id_aluimm, id_shift: ALU op, imm-as-B select, shamt-as-A select
//   id_inA, id_inB, id_imm      : operands and extended immediate
//   id_destR, ID_ins_type/number: destination register, debug tags
//   ex_*                        : registered/computed results to memory stage
//   EXE_ins_type/number         : debug tags (bubble tag while stalled)
//   ex_stall                    : freeze request to fetch/decode
// Stall contract: while ex_stall=1 the ID/EXE register holds and decode must
// hold its outputs; the instruction on id_* is consumed on the first rising
// edge at which ex_stall=0.
// ---------------------------------------------------------------------------
module exe_stage import exe_pkg::*; #(
    parameter int         MUL_STEPS = 32,
    parameter logic [3:0] NOP_TYPE  = NOP_TYPE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_wreg,
    input  logic        id_m2reg,
    input  logic        id_wmem,
    input  logic [3:0]  id_aluc,
    input  logic        id_aluimm,
    input  logic        id_shift,
    input  logic [31:0] id_inA,
    input  logic [31:0] id_inB,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_destR,
    input  logic [3:0]  ID_ins_type,
    input  logic [3:0]  ID_ins_number,
    output logic        ex_wreg,
    output logic        ex_m2reg,
    output logic        ex_wmem,
    output logic [31:0] ex_aluR,
    output logic [31:0] ex_inB,
    output logic [4:0]  ex_destR,
    output logic [3:0]  EXE_ins_type,
    output logic [3:0]  EXE_ins_number,
    output logic        ex_stall
);

    logic        r_wreg, r_m2reg, r_wmem, r_aluimm, r_shift;
    logic [3:0]  r_aluc, r_ins_type, r_ins_number;
    logic [31:0] r_inA, r_inB, r_imm;
    logic [4:0]  r_destR;

    logic [31:0] alu_a, alu_b, alu_res;
    logic        stall;

    // ID/EXE register; type tag resets to the bubble code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wreg       <= 1'b0;
            r_m2reg      <= 1'b0;
            r_wmem       <= 1'b0;
            r_aluc       <= '0;
            r_aluimm     <= 1'b0;
            r_shift      <= 1'b0;
            r_inA        <= '0;
            r_inB        <= '0;
            r_imm        <= '0;
            r_destR      <= '0;
            r_ins_type   <= NOP_TYPE;
            r_ins_number <= '0;
        end else if (!stall) begin
            r_wreg       <= id_wreg;
            r_m2reg      <= id_m2reg;
            r_wmem       <= id_wmem;
            r_aluc       <= id_aluc;
            r_aluimm     <= id_aluimm;
            r_shift      <= id_shift;
            r_inA        <= id_inA;
            r_inB        <= id_inB;
            r_imm        <= id_imm;
            r_destR      <= id_destR;
            r_ins_type   <= ID_ins_type;
            r_ins_number <= ID_ins_number;
        end
    end

    assign alu_b = r_aluimm ? r_imm : r_inB;
    assign alu_a = r_shift ? {27'b0, r_imm[10:6]} : r_inA;

    // MUL (and 13..15) fall to the default: its result comes from mul_seq.
    always_comb begin
        alu_res = '0;
        case (r_aluc)
            ALU_ADD:  alu_res = alu_a + alu_b;
            ALU_SUB:  alu_res = alu_a - alu_b;
            ALU_AND:  alu_res = alu_a & alu_b;
            ALU_OR:   alu_res = alu_a | alu_b;
            ALU_XOR:  alu_res = alu_a ^ alu_b;
            ALU_NOR:  alu_res = ~(alu_a | alu_b);
            ALU_SLT:  alu_res = {31'b0, ($signed(alu_a) < $signed(alu_b))};
            ALU_SLTU: alu_res = {31'b0, (alu_a < alu_b)};
            ALU_SLL:  alu_res = alu_b << alu_a[4:0];
            ALU_SRL:  alu_res = alu_b >> alu_a[4:0];
            ALU_SRA:  alu_res = $unsigned($signed(alu_b) >>> alu_a[4:0]);
            ALU_LUI:  alu_res = {alu_b[15:0], 16'b0};
            default:  alu_res = '0;
        endcase
    end

`ifdef EXE_MULDIV_EN
    logic        mul_busy, mul_done;
    logic [63:0] mul_product;
    mul_state_t  mul_state;
    logic        unused_mul_hi;

    mul_seq #(.STEPS(MUL_STEPS)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (r_aluc == ALU_MUL),
        .a       (alu_a),
        .b       (alu_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product),
        .state   (mul_state)
    );

    // Stall covers the IDLE cycle that launches the MUL plus all BUSY steps;
    // DONE releases the register so the next instruction is latched there.
    assign stall         = ((mul_state == MUL_IDLE) && (r_aluc == ALU_MUL)) || mul_busy;
    assign ex_aluR       = mul_done ? mul_product[31:0] : alu_res;
    assign unused_mul_hi = ^mul_product[63:32];
`else
    assign stall   = 1'b0;
    assign ex_aluR = alu_res;
`endif

    assign ex_stall       = stall;
    assign ex_wreg        = r_wreg  & ~stall;
    assign ex_m2reg       = r_m2reg & ~stall;
    assign ex_wmem        = r_wmem  & ~stall;
    assign ex_inB         = r_inB;
    assign ex_destR       = r_destR;
    assign EXE_ins_type   = stall ? NOP_TYPE : r_ins_type;
    assign EXE_ins_number = r_ins_number;

endmodule
